// File: rtl/idelay_tap_sweeper.sv
// IDELAY tap sweeper: steps taps 0..31, counts bit errors over a fixed sample
// window per tap into a bin memory, then streams (tap, count) records out.
module idelay_tap_sweeper #(
  parameter int WINDOW_LEN    = 65536,
  parameter int SETTLE_CYCLES = 64,
  parameter int COUNT_WIDTH   = 24
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [4:0]             DELAY,
  output logic                   DELAY_LD,
  input  logic                   SAMPLE_STB,
  input  logic                   SAMPLE_ERR,
  output logic                   O_STB,
  output logic [4:0]             O_TAP,
  output logic [COUNT_WIDTH-1:0] O_COUNT,
  input  logic                   O_RDY,
  output logic [2:0]             dbg_state
);

  // Output handshake: a record transfers on the cycle O_STB && O_RDY; while
  // O_STB is high and O_RDY low, O_TAP/O_COUNT hold their value.

  localparam int SW = $clog2(WINDOW_LEN + 1);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SETTLE   = 3'd2,
    MEASURE  = 3'd3,
    STORE    = 3'd4,
    DUMP_RD  = 3'd5,
    DUMP_OUT = 3'd6,
    FINISH   = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [4:0]             tap_q, tap_d;
  logic [4:0]             idx_q, idx_d;
  logic [TW-1:0]          settle_q, settle_d;
  logic [SW-1:0]          sample_q, sample_d;
  logic [COUNT_WIDTH-1:0] err_q, err_d;
  logic [4:0]             delay_q, delay_d;
  logic                   delay_ld_q, delay_ld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   o_stb_q, o_stb_d;
  logic [4:0]             o_tap_q, o_tap_d;
  logic [COUNT_WIDTH-1:0] o_count_q, o_count_d;
  logic                   bin_we;
  logic [COUNT_WIDTH-1:0] bin_mem [32];

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    sample_d  = sample_q;
    err_d     = err_q;
    delay_d   = delay_q;
    o_tap_d   = o_tap_q;
    o_count_d = o_count_q;
    bin_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          tap_d   = 5'd0;
          delay_d = 5'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == TW'(SETTLE_CYCLES - 1)) begin
          sample_d = '0;
          err_d    = '0;
          state_d  = MEASURE;
        end else begin
          settle_d = settle_q + TW'(1);
        end
      end
      MEASURE: begin
        if (SAMPLE_STB) begin
          sample_d = sample_q + SW'(1);
          // Error count sticks at all-ones rather than wrapping.
          if (SAMPLE_ERR && (err_q != {COUNT_WIDTH{1'b1}})) begin
            err_d = err_q + COUNT_WIDTH'(1);
          end
          if (sample_q == SW'(WINDOW_LEN - 1)) begin
            state_d = STORE;
          end
        end
      end
      STORE: begin
        bin_we = 1'b1;
        if (tap_q == 5'd31) begin
          idx_d   = 5'd0;
          state_d = DUMP_RD;
        end else begin
          tap_d   = tap_q + 5'd1;
          delay_d = tap_q + 5'd1;
          state_d = LOAD;
        end
      end
      DUMP_RD: begin
        o_tap_d   = idx_q;
        o_count_d = bin_mem[idx_q];
        state_d   = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (O_RDY) begin
          if (idx_q == 5'd31) begin
            delay_d = 5'd0;
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = DUMP_RD;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered strobes/flags are decoded from the next state so they line up
    // exactly with the state they describe.
    delay_ld_d = (state_d == LOAD) || (state_d == FINISH);
    done_d     = (state_d == FINISH);
    busy_d     = (state_d != IDLE);
    o_stb_d    = (state_d == DUMP_OUT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      idx_q      <= '0;
      settle_q   <= '0;
      sample_q   <= '0;
      err_q      <= '0;
      delay_q    <= '0;
      delay_ld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      o_stb_q    <= 1'b0;
      o_tap_q    <= '0;
      o_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      sample_q   <= sample_d;
      err_q      <= err_d;
      delay_q    <= delay_d;
      delay_ld_q <= delay_ld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      o_stb_q    <= o_stb_d;
      o_tap_q    <= o_tap_d;
      o_count_q  <= o_count_d;
    end
  end

  // Bins are not reset: every bin is written during the sweep before the dump reads it.
  always_ff @(posedge CLK) begin
    if (bin_we) begin
      bin_mem[tap_q] <= err_q;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DELAY     = delay_q;
  assign DELAY_LD  = delay_ld_q;
  assign O_STB     = o_stb_q;
  assign O_TAP     = o_tap_q;
  assign O_COUNT   = o_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_idelay_tap_sweeper.sv
// Bench for idelay_tap_sweeper: table of sweep scenarios plus directed reset,
// abort and mid-sweep START sequences; a second instance uses a 3-bit counter.
module tb_idelay_tap_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sample_stb, sample_err, o_rdy;
  logic        busy, done, delay_ld, o_stb;
  logic [4:0]  delay, o_tap;
  logic [23:0] o_count;
  logic [2:0]  dbg_state;
  logic        busy2, done2, delay_ld2, o_stb2;
  logic [4:0]  delay2, o_tap2;
  logic [2:0]  o_count2;
  logic [2:0]  dbg_state2;

  idelay_tap_sweeper #(.WINDOW_LEN(16), .SETTLE_CYCLES(4), .COUNT_WIDTH(24)) dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done),
    .DELAY(delay), .DELAY_LD(delay_ld), .SAMPLE_STB(sample_stb),
    .SAMPLE_ERR(sample_err), .O_STB(o_stb), .O_TAP(o_tap),
    .O_COUNT(o_count), .O_RDY(o_rdy), .dbg_state(dbg_state)
  );

  idelay_tap_sweeper #(.WINDOW_LEN(16), .SETTLE_CYCLES(4), .COUNT_WIDTH(3)) dut_sat (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy2), .DONE(done2),
    .DELAY(delay2), .DELAY_LD(delay_ld2), .SAMPLE_STB(sample_stb),
    .SAMPLE_ERR(sample_err), .O_STB(o_stb2), .O_TAP(o_tap2),
    .O_COUNT(o_count2), .O_RDY(o_rdy), .dbg_state(dbg_state2)
  );

  typedef struct {
    int          mode;   // 0 clean, 1 error window 10..14, 2 sparse, 3 all errors
    bit          bp;     // backpressure on the output stream
    bit          mid;    // extra START pulse in the middle of the sweep
    logic [23:0] cin;    // expected count, taps 10..14
    logic [23:0] cout;   // expected count, other taps
    logic [2:0]  c2in;   // same for the 3-bit instance
    logic [2:0]  c2out;
  } vec_t;

  vec_t tbl[5];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  bit bp = 0;
  int rec_n, bp_cnt, since, stb_n, done_n, done_cyc, start_cyc;
  bit busy_at_done;
  bit stalled = 0;
  logic [4:0]  st_tap;
  logic [23:0] st_cnt;
  logic        s_busy, s_done, s_ld, s_stb;
  logic [4:0]  s_delay, s_tap;
  logic [23:0] s_count;

  logic [4:0]  ld_q[$];
  logic [4:0]  tap_q[$];
  logic [23:0] cnt_q[$];
  logic [4:0]  tap2_q[$];
  logic [2:0]  cnt2_q[$];
  logic [23:0] exp_q[$];
  logic [2:0]  exp2_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then drive inputs just after the rising edge.
  task automatic step();
    @(negedge clk);
    s_busy = busy; s_done = done; s_ld = delay_ld; s_stb = o_stb;
    s_delay = delay; s_tap = o_tap; s_count = o_count;
    if (rst) begin
      stalled = 0;
    end else begin
      if (delay_ld) ld_q.push_back(delay);
      if (done) begin
        done_n++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (stalled) chk($sformatf("stall_hold tap=%0d", st_tap), {2'b0, o_stb, o_tap, o_count},
                       {2'b0, 1'b1, st_tap, st_cnt});
      stalled = o_stb && !o_rdy;
      st_tap = o_tap;
      st_cnt = o_count;
      if (o_stb && o_rdy) begin
        tap_q.push_back(o_tap);
        cnt_q.push_back(o_count);
        rec_n++;
      end
      if (o_stb2 && o_rdy) begin
        tap2_q.push_back(o_tap2);
        cnt2_q.push_back(o_count2);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (delay_ld) since = 0; else since++;
    case (mode)
      1: begin
        sample_stb = 1'b1;
        sample_err = ((delay >= 5'd10) && (delay <= 5'd14)) || (since <= 4);
      end
      2: begin
        sample_stb = (cyc % 3 == 0);
        if (sample_stb) begin
          sample_err = (stb_n % 4 == 3);
          stb_n++;
        end else begin
          sample_err = 1'($urandom_range(0, 1));
        end
      end
      3: begin
        sample_stb = 1'b1;
        sample_err = 1'b1;
      end
      default: begin
        sample_stb = 1'b1;
        sample_err = 1'b0;
      end
    endcase
    if (!bp || rec_n < 5) begin
      o_rdy = 1'b1;
    end else if (bp_cnt < 10) begin
      o_rdy = 1'b0;
      bp_cnt++;
    end else begin
      o_rdy = ~o_rdy;
    end
  endtask

  task automatic run_sweep(input vec_t v, input int row);
    int dur;
    mode = v.mode; bp = v.bp;
    rec_n = 0; bp_cnt = 0; done_n = 0; done_cyc = 0;
    ld_q.delete(); tap_q.delete(); cnt_q.delete(); tap2_q.delete(); cnt2_q.delete();
    exp_q.delete(); exp2_q.delete();
    for (int t = 0; t < 32; t++) begin
      exp_q.push_back((t >= 10 && t <= 14) ? v.cin : v.cout);
      exp2_q.push_back((t >= 10 && t <= 14) ? v.c2in : v.c2out);
    end
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    step();
    chk($sformatf("row%0d busy_after_start", row), 32'(s_busy), 32'd1);
    for (int i = 0; i < 6000 && done_n == 0; i++) begin
      if (v.mid && i == 300) start = 1'b1;
      step();
      start = 1'b0;
    end
    chk($sformatf("row%0d done_seen", row), 32'(done_n >= 1), 32'd1);
    if (v.mode != 2 && !v.bp) begin
      dur = done_cyc - start_cyc;
      chk($sformatf("row%0d duration=%0d", row, dur), 32'(dur >= 769 - 64 && dur <= 769 + 64), 32'd1);
    end
    chk($sformatf("row%0d busy_at_done", row), 32'(busy_at_done), 32'd1);
    step();
    chk($sformatf("row%0d busy_after_done", row), 32'(s_busy), 32'd0);
    repeat (4) step();
    chk($sformatf("row%0d done_pulses", row), 32'(done_n), 32'd1);
    chk($sformatf("row%0d ld_count", row), 32'(ld_q.size()), 32'd33);
    for (int i = 0; i < ld_q.size() && i < 33; i++)
      chk($sformatf("row%0d ld_val%0d", row, i), 32'(ld_q[i]), (i < 32) ? 32'(i) : 32'd0);
    chk($sformatf("row%0d rec_count", row), 32'(tap_q.size()), 32'd32);
    chk($sformatf("row%0d rec2_count", row), 32'(tap2_q.size()), 32'd32);
    for (int i = 0; i < tap_q.size() && i < 32; i++) begin
      chk($sformatf("row%0d tap%0d", row, i), 32'(tap_q[i]), 32'(i));
      chk($sformatf("row%0d count%0d", row, i), 32'(cnt_q[i]), 32'(exp_q[i]));
    end
    for (int i = 0; i < tap2_q.size() && i < 32; i++) begin
      chk($sformatf("row%0d sat_tap%0d", row, i), 32'(tap2_q[i]), 32'(i));
      chk($sformatf("row%0d sat_count%0d", row, i), 32'(cnt2_q[i]), 32'(exp2_q[i]));
    end
  endtask

  initial begin
    tbl[0] = '{mode: 0, bp: 0, mid: 0, cin: 24'd0,  cout: 24'd0,  c2in: 3'd0, c2out: 3'd0};
    tbl[1] = '{mode: 1, bp: 0, mid: 0, cin: 24'd16, cout: 24'd0,  c2in: 3'd7, c2out: 3'd0};
    tbl[2] = '{mode: 2, bp: 0, mid: 1, cin: 24'd4,  cout: 24'd4,  c2in: 3'd4, c2out: 3'd4};
    tbl[3] = '{mode: 0, bp: 1, mid: 0, cin: 24'd0,  cout: 24'd0,  c2in: 3'd0, c2out: 3'd0};
    tbl[4] = '{mode: 3, bp: 0, mid: 0, cin: 24'd16, cout: 24'd16, c2in: 3'd7, c2out: 3'd7};

    rst = 1'b1; start = 1'b0; sample_stb = 1'b0; sample_err = 1'b0; o_rdy = 1'b1;
    since = 100; stb_n = 0;
    repeat (3) step();
    chk("reset busy", 32'(s_busy), 32'd0);
    chk("reset done", 32'(s_done), 32'd0);
    chk("reset delay", 32'(s_delay), 32'd0);
    chk("reset delay_ld", 32'(s_ld), 32'd0);
    chk("reset o_stb", 32'(s_stb), 32'd0);
    chk("reset o_tap", 32'(s_tap), 32'd0);
    chk("reset o_count", 32'(s_count), 32'd0);
    chk("reset state", 32'(dbg_state), 32'd0);
    chk("reset sat outputs", {25'd0, busy2, done2, delay2}, 32'd0);
    chk("reset sat strobes", {26'd0, delay_ld2, o_stb2, dbg_state2, 1'b0}, 32'd0);
    rst = 1'b0;
    step();

    for (int r = 0; r < 5; r++) run_sweep(tbl[r], r);

    // Abort in the middle of MEASURE at tap 7.
    mode = 0; bp = 0; ld_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 1000 && ld_q.size() < 8; i++) step();
    chk("abort reached tap7", 32'(ld_q.size()), 32'd8);
    repeat (8) step();
    chk("abort delay before rst", 32'(s_delay), 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("abort busy", 32'(s_busy), 32'd0);
    chk("abort delay", 32'(s_delay), 32'd0);
    chk("abort delay_ld", 32'(s_ld), 32'd0);
    chk("abort o_stb", 32'(s_stb), 32'd0);
    chk("abort done", 32'(s_done), 32'd0);
    repeat (3) step();
    run_sweep(tbl[0], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
